// File: rtl/bw_ctu_jbusr_cken_seq.sv
// rtl/bw_ctu_jbusr_cken_seq.sv - jbusr cluster clock-enable / reset / debug-init sequencer
// Optional clock-enable test override: define JBUSR_CKEN_OVRD_EN to add tst_ckovrd.
module bw_ctu_jbusr_cken_seq #(
  parameter int CKEN_DLY  = 4,
  parameter int RST_WIDTH = 16,
  parameter int DBG_WIDTH = 8,
  parameter int CNT_W     = 8
) (
  input  logic gclk,
  input  logic arst_l,
  input  logic start,
  input  logic wrst_req,
  input  logic dbg_req,
  input  logic stop_req,
`ifdef JBUSR_CKEN_OVRD_EN
  input  logic tst_ckovrd,
`endif
  output logic cluster_cken,
  output logic grst_l,
  output logic gdbginit_l,
  output logic seq_busy,
  output logic seq_done
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_CKWAIT = 3'd1,
    S_RUN    = 3'd2,
    S_WRST   = 3'd3,
    S_DBG    = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CKEN_LD = CNT_W'(CKEN_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_WIDTH - 1);
  localparam logic [CNT_W-1:0] DBG_LD  = CNT_W'(DBG_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cken_nxt, grst_nxt, dbginit_nxt, busy_nxt, done_nxt;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state        <= S_OFF;
      cnt          <= '0;
      cluster_cken <= 1'b0;
      grst_l       <= 1'b0;
      gdbginit_l   <= 1'b0;
      seq_busy     <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cluster_cken <= cken_nxt;
      grst_l       <= grst_nxt;
      gdbginit_l   <= dbginit_nxt;
      seq_busy     <= busy_nxt;
      seq_done     <= done_nxt;
    end
  end

  // Requests arriving outside RUN are simply not looked at, so pulses are dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? cnt : cnt - CNT_ONE;
    unique case (state)
      S_OFF: begin
        if (start) begin
          state_nxt = S_CKWAIT;
          cnt_nxt   = CKEN_LD;
        end
      end
      S_CKWAIT, S_WRST, S_DBG: begin
        if (cnt_zero) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (wrst_req) begin
          state_nxt = S_WRST;
          cnt_nxt   = RST_LD;
        end else if (dbg_req) begin
          state_nxt = S_DBG;
          cnt_nxt   = DBG_LD;
        end else if (stop_req) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (!stop_req) state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are a pure function of the next state and registered alongside it.
  always_comb begin
    cken_nxt    = 1'b0;
    grst_nxt    = 1'b0;
    dbginit_nxt = 1'b0;
    busy_nxt    = 1'b1;
    done_nxt    = 1'b0;
    unique case (state_nxt)
      S_OFF: begin
        busy_nxt = 1'b0;
      end
      S_CKWAIT, S_WRST: begin
        cken_nxt = 1'b1;
      end
      S_RUN: begin
        cken_nxt    = 1'b1;
        grst_nxt    = 1'b1;
        dbginit_nxt = 1'b1;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b1;
      end
      S_DBG: begin
        cken_nxt = 1'b1;
        grst_nxt = 1'b1;
      end
      S_STOP: begin
        grst_nxt    = 1'b1;
        dbginit_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
`ifdef JBUSR_CKEN_OVRD_EN
    cken_nxt = cken_nxt | tst_ckovrd;
`endif
  end

endmodule

// File: tb/tb_bw_ctu_jbusr_cken_seq.sv
// tb/tb_bw_ctu_jbusr_cken_seq.sv - randomized scoreboard bench for bw_ctu_jbusr_cken_seq
// Honours JBUSR_CKEN_OVRD_EN when the design is built with it.
module tb_bw_ctu_jbusr_cken_seq;

  localparam int CKEN_DLY  = 4;
  localparam int RST_WIDTH = 16;
  localparam int DBG_WIDTH = 8;
  localparam int N_CYC     = 3000;

  logic gclk = 1'b0;
  logic arst_l = 1'b0;
  logic start = 1'b0, wrst_req = 1'b0, dbg_req = 1'b0, stop_req = 1'b0;
  logic tst_ckovrd = 1'b0;
  logic cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done;

  always #5 gclk = ~gclk;

  bw_ctu_jbusr_cken_seq #(
    .CKEN_DLY(CKEN_DLY), .RST_WIDTH(RST_WIDTH), .DBG_WIDTH(DBG_WIDTH), .CNT_W(8)
  ) dut (
    .gclk(gclk),
    .arst_l(arst_l),
    .start(start),
    .wrst_req(wrst_req),
    .dbg_req(dbg_req),
    .stop_req(stop_req),
`ifdef JBUSR_CKEN_OVRD_EN
    .tst_ckovrd(tst_ckovrd),
`endif
    .cluster_cken(cluster_cken),
    .grst_l(grst_l),
    .gdbginit_l(gdbginit_l),
    .seq_busy(seq_busy),
    .seq_done(seq_done)
  );

  typedef struct packed {
    logic cken;
    logic grst;
    logic dbg;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_cyc = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cur_cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".cluster_cken"}, cluster_cken, e.cken);
    chk({tag, ".grst_l"},       grst_l,       e.grst);
    chk({tag, ".gdbginit_l"},   gdbginit_l,   e.dbg);
    chk({tag, ".seq_busy"},     seq_busy,     e.busy);
    chk({tag, ".seq_done"},     seq_done,     e.done);
  endtask

  // Monitor: every edge the DUT presents a new output word; compare against the queue head.
  initial begin
    forever begin
      @(posedge gclk);
      #1;
      if (exp_q.size() > 0) chk_all("edge", exp_q.pop_front());
    end
  end

  // Reference model in terms of absolute edge numbers: when the sequencer returns to RUN
  // and until when each header line is held low.
  bit powered = 0;
  bit stopped = 0;
  int busy_until = 0;
  int rst_until  = 0;
  int dbg_until  = 0;

  function automatic exp_t model_edge(input int n, input bit rst_ok, input bit st,
                                      input bit wr, input bit db, input bit sp, input bit ov);
    exp_t e;
    bit   in_run;
    e = '0;
    if (!rst_ok) begin
      powered = 0;
      stopped = 0;
      return e;
    end
    in_run = powered && !stopped && (n > busy_until);
    if (!powered) begin
      if (st) begin
        powered    = 1;
        stopped    = 0;
        busy_until = n + CKEN_DLY;
        rst_until  = busy_until;
        dbg_until  = busy_until;
      end
    end else if (stopped) begin
      if (!sp) begin
        stopped    = 0;
        busy_until = n;
      end
    end else if (in_run) begin
      if (wr) begin
        busy_until = n + RST_WIDTH;
        rst_until  = busy_until;
        dbg_until  = busy_until;
      end else if (db) begin
        busy_until = n + DBG_WIDTH;
        dbg_until  = busy_until;
      end else if (sp) begin
        stopped = 1;
      end
    end
    e.cken = (powered && !stopped) || ov;
    e.grst = powered && (n >= rst_until);
    e.dbg  = powered && (n >= dbg_until);
    e.busy = powered && (stopped || n < busy_until);
    e.done = powered && !stopped && (n >= busy_until);
    return e;
  endfunction

  initial begin
    int   rst_hold;
    bit   ov_used;
    exp_t zeros;
    zeros    = '0;
    rst_hold = 3;
`ifdef JBUSR_CKEN_OVRD_EN
    ov_used = 1;
`else
    ov_used = 0;
`endif
    #1;
    chk_all("reset", zeros);
    for (int n = 1; n <= N_CYC; n++) begin
      @(negedge gclk);
      cur_cyc = n;
      if (rst_hold == 0 && $urandom_range(0, 299) == 0) begin
        rst_hold = $urandom_range(1, 3);
        arst_l   = 1'b0;
        #1;
        chk_all("async_rst", zeros);
      end
      if (rst_hold > 0) begin
        arst_l = 1'b0;
        rst_hold--;
      end else begin
        arst_l = 1'b1;
      end
      start    = ($urandom_range(0, 3) == 0);
      wrst_req = ($urandom_range(0, 24) == 0);
      dbg_req  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 99) == 0) begin
        wrst_req = 1'b1;
        dbg_req  = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) stop_req = ~stop_req;
      if (ov_used && $urandom_range(0, 30) == 0) tst_ckovrd = ~tst_ckovrd;
      exp_q.push_back(model_edge(n, arst_l, start, wrst_req, dbg_req, stop_req,
                                 ov_used && tst_ckovrd));
    end
    @(posedge gclk);
    #2;
    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
